// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbitration slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_defs;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } ArbState_t;

   // Upper bound on requesters any arbiter instance in this slice supports.
   localparam int ARB_MAX_NREQ = 8;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner select: first set bit of req searching ptr+1, ptr+2, ... modulo N.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when to register the winner.
// Ports: req (request vector), ptr (last winner index), win (one-hot winner),
//        win_idx (winner index), any (at least one request present).
module rr_pick #(
   parameter int N = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] win_idx,
   output logic          any
);

   logic [IW-1:0] cand;

   // Walk the N candidates in priority order starting just after ptr; the
   // last step (i == N) revisits ptr itself, so it has lowest priority.
   always_comb begin
      win     = '0;
      win_idx = '0;
      any     = 1'b0;
      cand    = '0;
      for (int i = 1; i <= N; i++) begin
         cand = IW'((int'(ptr) + i) % N);
         if (!any && req[cand]) begin
            any       = 1'b1;
            win[cand] = 1'b1;
            win_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART tx byte path among NREQ requesters.
// Latency: 1 cycle to arbitrate from idle; data path is combinational (no added latency).
// Backpressure: tx_d_ready_i and tx_enable_i pass straight through to the granted req_ready_o bit.
// Ports: clk/rst (sync, active-high); tx_enable_i gates all traffic; req_valid_i/req_data_i/
//        req_last_i/req_ready_o per-requester byte streams; tx_d_o/tx_d_valid_o/tx_d_ready_i to
//        the transmitter; grant_o one-hot grant; busy_o high while a grant is held.
// Optional: define UART_TX_ARB_STATS_EN to add pkt_cnt_o/byte_cnt_o (16-bit wrapping per requester).
module uart_tx_arbiter
   import uart_defs::*;
#(
   parameter int NREQ      = 4,
   parameter int MAX_BURST = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_enable_i,
   input  logic [NREQ-1:0]   req_valid_i,
   input  logic [NREQ*8-1:0] req_data_i,
   input  logic [NREQ-1:0]   req_last_i,
   output logic [NREQ-1:0]   req_ready_o,
   output logic [7:0]        tx_d_o,
   output logic              tx_d_valid_o,
   input  logic              tx_d_ready_i,
   output logic [NREQ-1:0]   grant_o,
   output logic              busy_o
`ifdef UART_TX_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0] pkt_cnt_o,
   output logic [NREQ*16-1:0] byte_cnt_o
`endif
);

   localparam int CW = $clog2(MAX_BURST + 1);
   localparam int IW = $clog2(NREQ);

   ArbState_t       state;
   logic [NREQ-1:0] grant_q;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   rr_ptr;
   logic [CW-1:0]   burst_cnt;
   logic            busy_q;

   logic [NREQ-1:0] pick_win;
   logic [IW-1:0]   pick_idx;
   logic            pick_any;
   logic [7:0]      sel_dat;
   logic            in_grant;
   logic            accept;
   logic            burst_end;

   rr_pick #(.N(NREQ)) u_rr_pick (
      .req     (req_valid_i),
      .ptr     (rr_ptr),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   assign in_grant  = (state == ARB_GRANT);
   assign burst_end = (burst_cnt == CW'(MAX_BURST - 1));
   assign grant_o   = grant_q;
   assign busy_o    = busy_q;

   // Data path: granted requester's byte straight through, forced to 0 when
   // not valid so nothing downstream ever sees X from an idle requester.
   always_comb begin
      sel_dat = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IW'(k) == gidx) sel_dat = req_data_i[k*8 +: 8];
      end
      tx_d_valid_o = in_grant & req_valid_i[gidx] & tx_enable_i;
      tx_d_o       = tx_d_valid_o ? sel_dat : 8'h00;
      req_ready_o  = '0;
      if (in_grant) req_ready_o[gidx] = tx_d_ready_i & tx_enable_i;
      accept       = tx_d_valid_o & tx_d_ready_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         rr_ptr    <= IW'(NREQ - 1);
         burst_cnt <= '0;
         grant_q   <= '0;
         gidx      <= '0;
         busy_q    <= 1'b0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (tx_enable_i && pick_any) begin
                  grant_q   <= pick_win;
                  gidx      <= pick_idx;
                  burst_cnt <= '0;
                  busy_q    <= 1'b1;
                  state     <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (accept) begin
                  // Release on end of packet or when the burst budget is spent;
                  // a cut packet simply re-arbitrates for its remaining bytes.
                  if (req_last_i[gidx] || burst_end) begin
                     state     <= ARB_IDLE;
                     grant_q   <= '0;
                     busy_q    <= 1'b0;
                     rr_ptr    <= gidx;
                     burst_cnt <= '0;
                  end else begin
                     burst_cnt <= burst_cnt + CW'(1);
                  end
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

`ifdef UART_TX_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt_o  <= '0;
         byte_cnt_o <= '0;
      end else if (accept) begin
         for (int k = 0; k < NREQ; k++) begin
            if (IW'(k) == gidx) begin
               byte_cnt_o[k*16 +: 16] <= byte_cnt_o[k*16 +: 16] + 16'd1;
               if (req_last_i[k]) pkt_cnt_o[k*16 +: 16] <= pkt_cnt_o[k*16 +: 16] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, MAX_BURST=16).
// Inputs are driven 1 time unit after the rising edge, outputs sampled 1 unit later.
// Requester streams in the multi-requester phases come from a small byte-pointer model.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int MB   = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        tx_enable_i;
   logic [3:0]  req_valid_i;
   logic [31:0] req_data_i;
   logic [3:0]  req_last_i;
   logic [3:0]  req_ready_o;
   logic [7:0]  tx_d_o;
   logic        tx_d_valid_o;
   logic        tx_d_ready_i;
   logic [3:0]  grant_o;
   logic        busy_o;
`ifdef UART_TX_ARB_STATS_EN
   logic [63:0] pkt_cnt_o;
   logic [63:0] byte_cnt_o;
`endif

   uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MB)) dut (
      .clk          (clk),
      .rst          (rst),
      .tx_enable_i  (tx_enable_i),
      .req_valid_i  (req_valid_i),
      .req_data_i   (req_data_i),
      .req_last_i   (req_last_i),
      .req_ready_o  (req_ready_o),
      .tx_d_o       (tx_d_o),
      .tx_d_valid_o (tx_d_valid_o),
      .tx_d_ready_i (tx_d_ready_i),
      .grant_o      (grant_o),
      .busy_o       (busy_o)
`ifdef UART_TX_ARB_STATS_EN
      ,
      .pkt_cnt_o    (pkt_cnt_o),
      .byte_cnt_o   (byte_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;

   // Transfers seen by the transmitter (reset cycles excluded).
   always @(posedge clk) begin
      if (!rst && tx_d_valid_o && tx_d_ready_i) acc_cnt <= acc_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Requester model: requester k sends bytes k*64+idx, idx = 0..len-1.
   int          len [4];
   int          idx [4];
   logic [7:0]  log_d[$];
   logic [3:0]  log_g[$];

   task automatic drive_model();
      for (int k = 0; k < 4; k++) begin
         req_valid_i[k]        = (idx[k] < len[k]);
         req_data_i[k*8 +: 8]  = 8'(k*64 + idx[k]);
         req_last_i[k]         = (idx[k] == len[k] - 1);
      end
   endtask

   task automatic run_model(input int ncyc);
      logic [3:0] acc;
      repeat (ncyc) begin
         drive_model();
         #1;
         acc = req_ready_o & req_valid_i;
         if (tx_d_valid_o && tx_d_ready_i) begin
            log_d.push_back(tx_d_o);
            log_g.push_back(grant_o);
         end
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) if (acc[k]) idx[k]++;
      end
   endtask

   task automatic check_log(input string tag, input logic [7:0] exp_d[$]);
      int n;
      chk({tag, "_count"}, log_d.size(), exp_d.size());
      n = (log_d.size() < exp_d.size()) ? log_d.size() : exp_d.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), log_d[i], exp_d[i]);
         chk($sformatf("%s_grant%0d", tag, i), log_g[i], 4'b0001 << exp_d[i][7:6]);
      end
      log_d.delete();
      log_g.delete();
   endtask

   initial begin
      logic [7:0] exp_q[$];
      int a0;

      rst = 1'b1; tx_enable_i = 1'b1; tx_d_ready_i = 1'b1;
      req_valid_i = '0; req_data_i = '0; req_last_i = '0;
      for (int k = 0; k < 4; k++) begin len[k] = 0; idx[k] = 0; end
      repeat (3) @(posedge clk);
      #1;

      // Reset state
      chk("rst_grant", grant_o, 4'b0000);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_valid", tx_d_valid_o, 1'b0);
      chk("rst_ready", req_ready_o, 4'b0000);
      chk("rst_txd", tx_d_o, 8'h00);

      // Req0 3-byte packet 41,42,43
      rst = 1'b0;
      req_valid_i = 4'b0001; req_data_i[7:0] = 8'h41;
      a0 = acc_cnt;
      #1;
      chk("t1_arb_valid", tx_d_valid_o, 1'b0);
      tick();
      chk("t1_grant", grant_o, 4'b0001);
      chk("t1_busy", busy_o, 1'b1);
      chk("t1_valid", tx_d_valid_o, 1'b1);
      chk("t1_b0", tx_d_o, 8'h41);
      chk("t1_ready", req_ready_o, 4'b0001);
      tick();
      req_data_i[7:0] = 8'h42; #1;
      chk("t1_b1", tx_d_o, 8'h42);
      tick();
      req_data_i[7:0] = 8'h43; req_last_i = 4'b0001; #1;
      chk("t1_b2", tx_d_o, 8'h43);
      chk("t1_grant_held", grant_o, 4'b0001);
      tick();
      req_valid_i = '0; req_last_i = '0; #1;
      chk("t1_grant_rel", grant_o, 4'b0000);
      chk("t1_busy_rel", busy_o, 1'b0);
      chk("t1_accepts", acc_cnt - a0, 3);

      // tx_d_ready_i low for 5 cycles mid-packet (req0: 10,11,12)
      a0 = acc_cnt;
      req_valid_i = 4'b0001; req_data_i[7:0] = 8'h10;
      tick();
      tick();
      req_data_i[7:0] = 8'h11; tx_d_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t4_valid%0d", i), tx_d_valid_o, 1'b1);
         chk($sformatf("t4_ready%0d", i), req_ready_o, 4'b0000);
         chk($sformatf("t4_txd%0d", i), tx_d_o, 8'h11);
         tick();
      end
      tx_d_ready_i = 1'b1; #1;
      chk("t4_ready_back", req_ready_o, 4'b0001);
      tick();
      req_data_i[7:0] = 8'h12; req_last_i = 4'b0001; #1;
      chk("t4_b2", tx_d_o, 8'h12);
      tick();
      req_valid_i = '0; req_last_i = '0; #1;
      chk("t4_accepts", acc_cnt - a0, 3);
      chk("t4_grant_rel", grant_o, 4'b0000);

      // tx_enable_i low for 3 cycles mid-packet (req0: 20,21,22)
      a0 = acc_cnt;
      req_valid_i = 4'b0001; req_data_i[7:0] = 8'h20;
      tick();
      tick();
      req_data_i[7:0] = 8'h21; tx_enable_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("t5_valid%0d", i), tx_d_valid_o, 1'b0);
         chk($sformatf("t5_grant%0d", i), grant_o, 4'b0001);
         chk($sformatf("t5_ready%0d", i), req_ready_o, 4'b0000);
         tick();
      end
      tx_enable_i = 1'b1; #1;
      chk("t5_resume", tx_d_o, 8'h21);
      tick();
      req_data_i[7:0] = 8'h22; req_last_i = 4'b0001;
      tick();
      req_valid_i = '0; req_last_i = '0; #1;
      chk("t5_accepts", acc_cnt - a0, 3);

      // tx_enable_i low in idle with requests: no grant; then req2 wins (rr_ptr=0)
      tx_enable_i = 1'b0;
      req_valid_i = 4'b0101; req_data_i[7:0] = 8'h20; req_data_i[23:16] = 8'h55;
      req_last_i = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("t5_idle_grant%0d", i), grant_o, 4'b0000);
      end
      tx_enable_i = 1'b1;
      tick();
      chk("t5_rr_grant", grant_o, 4'b0100);
      chk("t5_rr_txd", tx_d_o, 8'h55);
      tick();
      req_valid_i = '0; req_last_i = '0; #1;
      chk("t5_rr_rel", grant_o, 4'b0000);

      // Reset during byte 2 of a 4-byte req0 packet (rr_ptr=2 -> req0 wins)
      req_valid_i = 4'b0001; req_data_i[7:0] = 8'h30;
      tick();
      tick();
      req_data_i[7:0] = 8'h31; rst = 1'b1;
      tick();
      chk("t6_grant", grant_o, 4'b0000);
      chk("t6_busy", busy_o, 1'b0);
      chk("t6_valid", tx_d_valid_o, 1'b0);
      chk("t6_ready", req_ready_o, 4'b0000);
      chk("t6_txd", tx_d_o, 8'h00);
      rst = 1'b0;
      req_valid_i = 4'b0011; req_data_i[7:0] = 8'h30; req_data_i[15:8] = 8'h90;
      tick();
      chk("t6_rr_first", grant_o, 4'b0001);
      chk("t6_txd_first", tx_d_o, 8'h30);

      // Req0 and req2 valid at reset exit, 2-byte packets each
      req_valid_i = '0; rst = 1'b1;
      tick();
      len[0] = 2; len[2] = 2;
      rst = 1'b0;
      run_model(12);
      exp_q = '{8'h00, 8'h01, 8'h80, 8'h81};
      check_log("t2a", exp_q);
      // rr_ptr=2 now: req3 is searched before req0
      len[0] = 1; idx[0] = 0; len[3] = 1; idx[3] = 0;
      run_model(8);
      exp_q = '{8'hC0, 8'h00};
      check_log("t2b", exp_q);

      // Req1 40-byte packet with req3 pending: 16 bytes, req3 packet, then the rest
      len[1] = 40; idx[1] = 0; len[3] = 2; idx[3] = 0;
      run_model(60);
      exp_q.delete();
      for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h40 + i));
      exp_q.push_back(8'hC0);
      exp_q.push_back(8'hC1);
      for (int i = 16; i < 40; i++) exp_q.push_back(8'(8'h40 + i));
      check_log("t3", exp_q);
      chk("t3_idle_end", grant_o, 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares the single UART transmit datapath between NREQ byte-stream requesters (e.g. CPU CSR path, DMA, debug console).
- Sits between the requesters and the transmitter's tx_d/tx_d_valid input.
- Grants at packet granularity: a grant is held until the requester's last byte, or until a burst limit forces rotation.
- Gates all traffic with the CSR-derived transmit enable.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_BURST, 16, max bytes accepted per grant before forced rotation (>=1)
CW, $clog2(MAX_BURST+1), burst counter width (derived, not overridable)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
tx_enable_i  input  1  transmit enable from the UART CSR block
req_valid_i  input  NREQ  per-requester byte valid
req_data_i  input  NREQ*8  per-requester byte; requester k uses bits [8k+7:8k]
req_last_i  input  NREQ  byte is last of packet
req_ready_o  output  NREQ  byte accepted this cycle
tx_d_o  output  8  byte to the transmitter
tx_d_valid_o  output  1  byte valid to the transmitter
tx_d_ready_i  input  1  transmitter can accept a byte
grant_o  output  NREQ  one-hot current grant; all-zero in ARB_IDLE
busy_o  output  1  high in ARB_GRANT

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - state = ARB_IDLE
  - rr_ptr = NREQ-1, so requester 0 wins first
  - burst_cnt = 0
  - grant_o = 0, busy_o = 0, tx_d_valid_o = 0, req_ready_o = 0, tx_d_o = 0
- States: ARB_IDLE, ARB_GRANT.
- ARB_IDLE:
  - If tx_enable_i and any req_valid_i: select the first valid requester searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Register the selection into grant_q, clear burst_cnt, go to ARB_GRANT.
  - Arbitration costs exactly 1 cycle. The first byte can be accepted the cycle after request.
- ARB_GRANT (g = granted index):
  - tx_d_o = req_data_i[g], combinational.
  - tx_d_valid_o = req_valid_i[g] & tx_enable_i.
  - req_ready_o[g] = tx_d_ready_i & tx_enable_i. All other ready bits are 0.
  - Accept: tx_d_valid_o & tx_d_ready_i. On accept, burst_cnt increments.
- Release (return to ARB_IDLE; rr_ptr <= g; grant_o clears next cycle) when either:
  - accept with req_last_i[g] = 1, or
  - accept with burst_cnt == MAX_BURST-1 (forced rotation; the rest of the packet re-arbitrates).
- tx_enable_i low in ARB_GRANT: grant is held, no transfer, tx_d_valid_o = 0.
- tx_enable_i low in ARB_IDLE: no new grant issued.
- The granted requester deasserting valid mid-packet: grant is held indefinitely. There is no timeout.
- Requester valid/data must stay stable until ready. Payload is never buffered; zero added latency on data.
- With a single active requester, back-to-back packets cost 1 idle cycle each (re-arbitration).
- Reset mid-packet: grant is dropped immediately and the partial packet is abandoned. The requester must re-send.
- tx_d_o drives 0 when tx_d_valid_o is low, to avoid X propagation.

Optional Feature:
- UART_TX_ARB_STATS_EN defined:
  - Adds output pkt_cnt_o (NREQ*16): per-requester count of completed packets (accept with last).
  - Adds output byte_cnt_o (NREQ*16): per-requester count of accepted bytes.
  - Both wrap at 16 bits, reset to 0, and have no clear input.
- Undefined: these ports and the counters do not exist.

Decomposition:
- uart_defs package gets:
  - ArbState_t enum {ARB_IDLE, ARB_GRANT}
  - ARB_MAX_NREQ = 8 constant
- Sub-module rr_pick (combinational): inputs req vector and rr_ptr; outputs one-hot winner and winner index. Reusable elsewhere.

Test Plan:
- Req0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx_d_ready_i=1 -> tx_d_o shows 41,42,43 on consecutive cycles starting 1 cycle after request; grant_o=0001 then 0000.
- Req0 and req2 both valid at reset exit, 2-byte packets each -> order req0 packet, then req2 packet; next simultaneous request goes to req2+1 search, so a waiting req1 or req3 wins before req0.
- Req1 streams a 40-byte packet, MAX_BURST=16, req3 pending -> req1 gets 16 bytes, req3 gets its packet, req1 resumes at byte 17.
- tx_d_ready_i low for 5 cycles mid-packet -> tx_d_valid_o stays 1, req_ready_o=0, tx_d_o stable, no byte lost or duplicated.
- tx_enable_i dropped mid-packet for 3 cycles -> tx_d_valid_o=0, grant_o unchanged; transfer resumes at the next byte. tx_enable_i=0 in ARB_IDLE with requests -> grant_o stays 0.
- rst pulsed during byte 2 of a 4-byte packet -> next cycle all outputs at reset values; with requesters 0 and 1 both valid, requester 0 wins again first.
